// File: rtl/mci_pkg.sv
// Shared types and constants for the MCU halt responder.
//   mci_halt_rsp_state_e   : responder FSM state encoding (also exported on state_o)
//   MCI_HALT_DRAIN_TIMEOUT : default drain budget in cycles
//   MCI_HALT_OUTSTANDING_W : default width of the outstanding-transaction counter
//   mci_tmo_width()        : width of a counter that must reach timeout-1 (never 0)
package mci_pkg;

  typedef enum logic [2:0] {
    HALT_RSP_RUN       = 3'd0,
    HALT_RSP_DRAIN     = 3'd1,
    HALT_RSP_HALT_CORE = 3'd2,
    HALT_RSP_HALTED    = 3'd3,
    HALT_RSP_RELEASE   = 3'd4
  } mci_halt_rsp_state_e;

  localparam int unsigned MCI_HALT_DRAIN_TIMEOUT = 1024;
  localparam int unsigned MCI_HALT_OUTSTANDING_W = 4;

  // A timeout of 1 still needs a 1-bit counter.
  function automatic int unsigned mci_tmo_width(input int unsigned timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/mci_outstanding_ctr.sv
// Saturating up/down count of outstanding MCU AXI transactions.
//   clk, rst_b       : clock, async active-low reset
//   issue_i          : a transaction was issued this cycle
//   done_i           : a transaction completed this cycle
//   cnt_o            : current outstanding count (saturates at 2^W-1)
//   underflow_err_o  : sticky, completion seen with nothing outstanding
module mci_outstanding_ctr
  import mci_pkg::*;
#(
  parameter int unsigned W = MCI_HALT_OUTSTANDING_W
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         issue_i,
  input  logic         done_i,
  output logic [W-1:0] cnt_o,
  output logic         underflow_err_o
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt_q, cnt_d;
  logic         uf_q,  uf_d;

  // Issue and done together cancel; done at zero flags instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    uf_d  = uf_q;
    case ({issue_i, done_i})
      2'b10: if (cnt_q != CNT_MAX) cnt_d = cnt_q + W'(1);
      2'b01: begin
        if (cnt_q == '0) uf_d  = 1'b1;
        else             cnt_d = cnt_q - W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q <= '0;
      uf_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      uf_q  <= uf_d;
    end
  end

  assign cnt_o           = cnt_q;
  assign underflow_err_o = uf_q;

endmodule

// File: rtl/mci_mcu_halt_responder.sv
// MCU-side responder to the MCI boot FSM halt handshake: on a halt request it
// blocks new fetches, drains outstanding AXI traffic, halts the core and acks;
// it releases the core once the boot FSM drops the request.
//   clk, rst_b           : clock, async active-low reset
//   halt_req_i           : level halt request from the boot FSM
//   txn_issue_i/done_i   : AXI issue / completion pulses from the MCU master
//   core_halted_i        : MCU core halted status
//   fetch_block_o        : block new fetches / AXI issues
//   core_halt_req_o      : halt request to the MCU core
//   halt_ack_o           : halted and drained
//   drain_timeout_err_o  : sticky, drain ran out of budget
//   cnt_underflow_err_o  : sticky, completion with nothing outstanding
//   outstanding_cnt_o    : outstanding transaction count
//   state_o              : FSM state (mci_halt_rsp_state_e)
module mci_mcu_halt_responder
  import mci_pkg::*;
#(
  parameter int unsigned OUTSTANDING_W = MCI_HALT_OUTSTANDING_W,
  parameter int unsigned DRAIN_TIMEOUT = MCI_HALT_DRAIN_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     halt_req_i,
  input  logic                     txn_issue_i,
  input  logic                     txn_done_i,
  input  logic                     core_halted_i,
  output logic                     fetch_block_o,
  output logic                     core_halt_req_o,
  output logic                     halt_ack_o,
  output logic                     drain_timeout_err_o,
  output logic                     cnt_underflow_err_o,
  output logic [OUTSTANDING_W-1:0] outstanding_cnt_o,
  output logic [2:0]               state_o
);

  localparam int unsigned TMO_W = mci_tmo_width(DRAIN_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DRAIN_TIMEOUT - 1);

  localparam logic [2:0] ST_RUN       = HALT_RSP_RUN;
  localparam logic [2:0] ST_DRAIN     = HALT_RSP_DRAIN;
  localparam logic [2:0] ST_HALT_CORE = HALT_RSP_HALT_CORE;
  localparam logic [2:0] ST_HALTED    = HALT_RSP_HALTED;
  localparam logic [2:0] ST_RELEASE   = HALT_RSP_RELEASE;

  logic [2:0]               state_q, state_d;
  logic [TMO_W-1:0]         tmo_q,   tmo_d;
  logic                     tmo_err_q, tmo_err_d;
  logic [OUTSTANDING_W-1:0] cnt;

  // Outstanding count runs in every state, independent of the FSM.
  mci_outstanding_ctr #(
    .W (OUTSTANDING_W)
  ) u_ctr (
    .clk             (clk),
    .rst_b           (rst_b),
    .issue_i         (txn_issue_i),
    .done_i          (txn_done_i),
    .cnt_o           (cnt),
    .underflow_err_o (cnt_underflow_err_o)
  );

  // Next state; timeout counter is zero everywhere but DRAIN, so entry clears it.
  always_comb begin
    state_d   = state_q;
    tmo_d     = '0;
    tmo_err_d = tmo_err_q;
    case (state_q)
      ST_RUN: begin
        if (halt_req_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (!halt_req_i) begin
          state_d = ST_RELEASE;
        end else if ((cnt == '0) && !txn_issue_i) begin
          state_d = ST_HALT_CORE;
        end else if ((tmo_q == TMO_LAST) && (cnt != '0)) begin
          tmo_err_d = 1'b1;
          state_d   = ST_HALT_CORE;
        end
      end
      ST_HALT_CORE: begin
        if (!halt_req_i)        state_d = ST_RELEASE;
        else if (core_halted_i) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        if (!halt_req_i) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        // A new request is only honoured once back in RUN.
        if (!core_halted_i) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= ST_RUN;
      tmo_q     <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  // Outputs decode the state register only; illegal encodings keep fetches blocked.
  always_comb begin
    fetch_block_o   = 1'b0;
    core_halt_req_o = 1'b0;
    halt_ack_o      = 1'b0;
    case (state_q)
      ST_RUN: ;
      ST_DRAIN: fetch_block_o = 1'b1;
      ST_HALT_CORE: begin
        fetch_block_o   = 1'b1;
        core_halt_req_o = 1'b1;
      end
      ST_HALTED: begin
        fetch_block_o   = 1'b1;
        core_halt_req_o = 1'b1;
        halt_ack_o      = 1'b1;
      end
      ST_RELEASE: fetch_block_o = 1'b1;
      default:    fetch_block_o = 1'b1;
    endcase
  end

  assign drain_timeout_err_o = tmo_err_q;
  assign outstanding_cnt_o   = cnt;
  assign state_o             = state_q;

endmodule

// File: tb/tb_mci_mcu_halt_responder.sv
// Directed bench for the MCU halt responder (drain budget shortened to 16).
module tb_mci_mcu_halt_responder;

  localparam int unsigned W   = 4;
  localparam int unsigned TMO = 16;

  localparam logic [2:0] S_RUN = 3'd0, S_DRAIN = 3'd1, S_HCORE = 3'd2,
                         S_HALTED = 3'd3, S_REL = 3'd4;

  logic         clk = 1'b0;
  logic         rst_b = 1'b0;
  logic         halt_req_i = 1'b0;
  logic         txn_issue_i = 1'b0;
  logic         txn_done_i = 1'b0;
  logic         core_halted_i = 1'b0;
  logic         fetch_block_o, core_halt_req_o, halt_ack_o;
  logic         drain_timeout_err_o, cnt_underflow_err_o;
  logic [W-1:0] outstanding_cnt_o;
  logic [2:0]   state_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mci_mcu_halt_responder #(
    .OUTSTANDING_W (W),
    .DRAIN_TIMEOUT (TMO)
  ) dut (
    .clk                 (clk),
    .rst_b               (rst_b),
    .halt_req_i          (halt_req_i),
    .txn_issue_i         (txn_issue_i),
    .txn_done_i          (txn_done_i),
    .core_halted_i       (core_halted_i),
    .fetch_block_o       (fetch_block_o),
    .core_halt_req_o     (core_halt_req_o),
    .halt_ack_o          (halt_ack_o),
    .drain_timeout_err_o (drain_timeout_err_o),
    .cnt_underflow_err_o (cnt_underflow_err_o),
    .outstanding_cnt_o   (outstanding_cnt_o),
    .state_o             (state_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // {fetch_block, core_halt_req, halt_ack} together with state.
  task automatic check_st(input string tag, input logic [2:0] st, input logic [2:0] fch);
    check({tag, ".state"}, 32'(state_o), 32'(st));
    check({tag, ".fch"}, 32'({fetch_block_o, core_halt_req_o, halt_ack_o}), 32'(fch));
  endtask

  task automatic pulse_issue(input int n);
    txn_issue_i = 1'b1;
    step(n);
    txn_issue_i = 1'b0;
  endtask

  task automatic pulse_done(input int n);
    txn_done_i = 1'b1;
    step(n);
    txn_done_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    step(2);
    rst_b = 1'b1;
    step(1);
  endtask

  initial begin
    // Reset state
    do_reset();
    check_st("rst", S_RUN, 3'b000);
    check("rst.cnt", 32'(outstanding_cnt_o), 32'd0);
    check("rst.errs", 32'({drain_timeout_err_o, cnt_underflow_err_o}), 32'd0);

    // 1: idle drain
    halt_req_i = 1'b1;
    step(1);
    check_st("t1.p1", S_DRAIN, 3'b100);
    step(1);
    check_st("t1.p2", S_HCORE, 3'b110);
    core_halted_i = 1'b1;
    step(1);
    check_st("t1.halted", S_HALTED, 3'b111);
    step(2);
    check_st("t1.hold", S_HALTED, 3'b111);
    halt_req_i = 1'b0;
    step(1);
    check_st("t1.rel", S_REL, 3'b100);
    step(1);
    check_st("t1.relhold", S_REL, 3'b100);
    core_halted_i = 1'b0;
    step(1);
    check_st("t1.run", S_RUN, 3'b000);

    // 2: drain with three outstanding
    pulse_issue(3);
    check("t2.cnt3", 32'(outstanding_cnt_o), 32'd3);
    halt_req_i = 1'b1;
    step(1);
    check_st("t2.drain", S_DRAIN, 3'b100);
    for (int k = 0; k < 3; k++) begin
      pulse_done(1);
      check("t2.cnt", 32'(outstanding_cnt_o), 32'(2 - k));
      check("t2.indrain", 32'(state_o), 32'(S_DRAIN));
      if (k < 2) step(4);
    end
    step(1);
    check_st("t2.hcore", S_HCORE, 3'b110);
    core_halted_i = 1'b1;
    step(1);
    check_st("t2.halted", S_HALTED, 3'b111);
    halt_req_i = 1'b0;
    step(1);
    core_halted_i = 1'b0;
    step(1);
    check_st("t2.run", S_RUN, 3'b000);
    check("t2.errs", 32'({drain_timeout_err_o, cnt_underflow_err_o}), 32'd0);

    // 5: abort from DRAIN (one txn held outstanding) and from HALT_CORE
    pulse_issue(1);
    halt_req_i = 1'b1;
    step(1);
    check_st("t5.drain", S_DRAIN, 3'b100);
    halt_req_i = 1'b0;
    step(1);
    check_st("t5.rel1", S_REL, 3'b100);
    halt_req_i = 1'b1;
    step(1);
    check_st("t5.run1", S_RUN, 3'b000);
    step(1);
    check_st("t5.retake", S_DRAIN, 3'b100);
    halt_req_i = 1'b0;
    step(1);
    step(1);
    pulse_done(1);
    check("t5.cnt0", 32'(outstanding_cnt_o), 32'd0);
    halt_req_i = 1'b1;
    step(2);
    check_st("t5.hcore", S_HCORE, 3'b110);
    halt_req_i = 1'b0;
    step(1);
    check_st("t5.rel2", S_REL, 3'b100);
    step(1);
    check_st("t5.run2", S_RUN, 3'b000);

    // 4: counter edges
    pulse_issue(5);
    check("t4.cnt5", 32'(outstanding_cnt_o), 32'd5);
    txn_issue_i = 1'b1;
    txn_done_i  = 1'b1;
    step(1);
    txn_issue_i = 1'b0;
    txn_done_i  = 1'b0;
    check("t4.both", 32'(outstanding_cnt_o), 32'd5);
    pulse_done(5);
    check("t4.down0", 32'(outstanding_cnt_o), 32'd0);
    check("t4.nouf", 32'(cnt_underflow_err_o), 32'd0);
    pulse_done(1);
    check("t4.uf.cnt", 32'(outstanding_cnt_o), 32'd0);
    check("t4.uf.err", 32'(cnt_underflow_err_o), 32'd1);
    pulse_issue(15);
    check("t4.cnt15", 32'(outstanding_cnt_o), 32'd15);
    pulse_issue(1);
    check("t4.sat", 32'(outstanding_cnt_o), 32'd15);
    pulse_done(15);
    check("t4.uf.sticky", 32'(cnt_underflow_err_o), 32'd1);
    do_reset();
    check("t4.uf.clr", 32'(cnt_underflow_err_o), 32'd0);

    // 3: drain timeout with two outstanding and no completions
    pulse_issue(2);
    halt_req_i = 1'b1;
    step(1);
    check_st("t3.drain", S_DRAIN, 3'b100);
    step(15);
    check_st("t3.last", S_DRAIN, 3'b100);
    check("t3.noerr", 32'(drain_timeout_err_o), 32'd0);
    step(1);
    check_st("t3.hcore", S_HCORE, 3'b110);
    check("t3.err", 32'(drain_timeout_err_o), 32'd1);
    core_halted_i = 1'b1;
    step(1);
    halt_req_i = 1'b0;
    step(1);
    core_halted_i = 1'b0;
    step(1);
    check_st("t3.run", S_RUN, 3'b000);
    check("t3.sticky", 32'(drain_timeout_err_o), 32'd1);

    // 6: async reset while HALTED (two still outstanding, so drain times out again)
    halt_req_i = 1'b1;
    step(17);
    core_halted_i = 1'b1;
    step(1);
    check_st("t6.halted", S_HALTED, 3'b111);
    #2;
    rst_b = 1'b0;
    #1;
    check_st("t6.rst", S_RUN, 3'b000);
    check("t6.cnt", 32'(outstanding_cnt_o), 32'd0);
    check("t6.errs", 32'({drain_timeout_err_o, cnt_underflow_err_o}), 32'd0);
    halt_req_i    = 1'b0;
    core_halted_i = 1'b0;
    step(1);
    rst_b = 1'b1;
    step(1);
    check_st("t6.post", S_RUN, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
